// File: rtl/data_mem_unit.sv
// Data memory stage: byte-lane store, synchronous load with extension,
// write-back mux, and a single-entry valid/ready output buffer.
module data_mem_unit #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] alu_result,
    input  logic          we,
    input  logic [2:0]    funct3,
    input  logic [31:0]   wd,
    input  logic [1:0]    result_src,
    input  logic [31:0]   pc_plus4,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   result,
    output logic          err
);

    localparam int LW = $clog2(DEPTH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_q, state_d;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;
    logic [LW-1:0] idx;
    logic [1:0]    off;
    logic          acc;
    logic          mem_acc;
    logic          mis;
    logic          ill;
    logic          bad;
    logic          err_d;
    logic [3:0]    be;
    logic [31:0]   wdata;

    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic [1:0]    src_q;
    logic [AW-1:0] alu_q;
    logic [31:0]   pc_q;
    logic          bad_q;
    logic          err_q;

    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ld;

    assign rsp_valid = (state_q == FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    assign acc       = req_valid && req_ready && rst_n;

    assign idx     = alu_result[LW+1:2];
    assign off     = alu_result[1:0];
    assign mem_acc = we || (result_src == 2'b01);
    assign mis     = ((funct3[1:0] == 2'b01) && off[0])
                  || ((funct3[1:0] == 2'b10) && (off != 2'b00));
    assign ill     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign bad     = mem_acc && (mis || ill);
    assign err_d   = bad || (result_src == 2'b11);

    always_comb begin
        be    = 4'b0000;
        wdata = wd;
        unique case (1'b1)
            (funct3[1:0] == 2'b00): begin
                be    = 4'b0001 << off;
                wdata = {4{wd[7:0]}};
            end
            (funct3[1:0] == 2'b01): begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd[15:0]}};
            end
            (funct3[1:0] == 2'b10): be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Read sees the pre-write word because both use non-blocking updates.
    always_ff @(posedge clk) begin
        if (acc) begin
            rdata_q <= mem[idx];
            if (we && !bad) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            off_q   <= '0;
            f3_q    <= '0;
            src_q   <= '0;
            alu_q   <= '0;
            pc_q    <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                off_q <= off;
                f3_q  <= funct3;
                src_q <= result_src;
                alu_q <= alu_result;
                pc_q  <= pc_plus4;
                bad_q <= bad;
                err_q <= err_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (acc) state_d = FULL;
            FULL:  if (rsp_ready && !acc) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign bsel = rdata_q[{off_q, 3'b000} +: 8];
    assign hsel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        ld = rdata_q;
        unique case (1'b1)
            (f3_q == 3'b000): ld = {{24{bsel[7]}}, bsel};
            (f3_q == 3'b100): ld = {24'h0, bsel};
            (f3_q == 3'b001): ld = {{16{hsel[15]}}, hsel};
            (f3_q == 3'b101): ld = {16'h0, hsel};
            default: ld = rdata_q;
        endcase
    end

    always_comb begin
        result = '0;
        unique case (src_q)
            2'b00: result = 32'(alu_q);
            2'b01: result = bad_q ? 32'h0 : ld;
            2'b10: result = pc_q;
            default: result = '0;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table plus handshake
// and reset sequences.
module tb_data_mem_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] alu_result;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wd;
    logic [1:0]  result_src;
    logic [31:0] pc_plus4;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        err;

    int n_tot = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [1:0]  src;
        logic [31:0] pc;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t vq[$];

    data_mem_unit #(.DEPTH(1024), .AW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .alu_result (alu_result),
        .we         (we),
        .funct3     (funct3),
        .wd         (wd),
        .result_src (result_src),
        .pc_plus4   (pc_plus4),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .result     (result),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [31:0] a, input logic w, input logic [2:0] f,
        input logic [31:0] d, input logic [1:0] s, input logic [31:0] p,
        input logic [31:0] r, input logic e);
        vec_t v;
        v.addr = a; v.we = w; v.f3 = f; v.wd = d;
        v.src = s; v.pc = p; v.res = r; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_result = v.addr;
        we         = v.we;
        funct3     = v.f3;
        wd         = v.wd;
        result_src = v.src;
        pc_plus4   = v.pc;
        req_valid  = 1'b1;
    endtask

    initial begin
        vq.push_back(mk(32'h10,   1, 3'b010, 32'hDEADBEEF, 2'b00, 0, 32'h10, 0));
        vq.push_back(mk(32'h10,   0, 3'b010, 0, 2'b01, 0, 32'hDEADBEEF, 0));
        vq.push_back(mk(32'h13,   1, 3'b000, 32'h80, 2'b00, 0, 32'h13, 0));
        vq.push_back(mk(32'h13,   0, 3'b000, 0, 2'b01, 0, 32'hFFFFFF80, 0));
        vq.push_back(mk(32'h13,   0, 3'b100, 0, 2'b01, 0, 32'h00000080, 0));
        vq.push_back(mk(32'h10,   0, 3'b010, 0, 2'b01, 0, 32'h80ADBEEF, 0));
        vq.push_back(mk(32'h11,   1, 3'b001, 32'h1234, 2'b00, 0, 32'h11, 1));
        vq.push_back(mk(32'h10,   0, 3'b010, 0, 2'b01, 0, 32'h80ADBEEF, 0));
        vq.push_back(mk(32'h12,   0, 3'b010, 0, 2'b01, 0, 32'h0, 1));
        vq.push_back(mk(32'h12,   0, 3'b001, 0, 2'b01, 0, 32'hFFFF80AD, 0));
        vq.push_back(mk(32'h10,   0, 3'b101, 0, 2'b01, 0, 32'h0000BEEF, 0));
        vq.push_back(mk(32'h10,   0, 3'b001, 0, 2'b01, 0, 32'hFFFFBEEF, 0));
        vq.push_back(mk(32'h1000, 1, 3'b010, 32'hCAFEF00D, 2'b00, 0, 32'h1000, 0));
        vq.push_back(mk(32'h0,    0, 3'b010, 0, 2'b01, 0, 32'hCAFEF00D, 0));
        vq.push_back(mk(32'h55,   0, 3'b000, 0, 2'b10, 32'h104, 32'h104, 0));
        vq.push_back(mk(32'h55,   0, 3'b000, 0, 2'b11, 32'h104, 32'h0, 1));
        vq.push_back(mk(32'h10,   0, 3'b011, 0, 2'b01, 0, 32'h0, 1));
        vq.push_back(mk(32'h20,   1, 3'b010, 32'h11111111, 2'b00, 0, 32'h20, 0));
        vq.push_back(mk(32'h20,   1, 3'b110, 32'h22222222, 2'b00, 0, 32'h20, 1));
        vq.push_back(mk(32'h20,   0, 3'b010, 0, 2'b01, 0, 32'h11111111, 0));
        vq.push_back(mk(32'h22,   1, 3'b001, 32'hABCD, 2'b00, 0, 32'h22, 0));
        vq.push_back(mk(32'h21,   0, 3'b000, 0, 2'b01, 0, 32'h11, 0));
        vq.push_back(mk(32'h23,   0, 3'b001, 0, 2'b00, 0, 32'h23, 0));
        vq.push_back(mk(32'h20,   1, 3'b010, 32'h55667788, 2'b01, 0, 32'hABCD1111, 0));
        vq.push_back(mk(32'h20,   0, 3'b010, 0, 2'b01, 0, 32'h55667788, 0));

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        alu_result = '0; we = 1'b0; funct3 = '0; wd = '0;
        result_src = '0; pc_plus4 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            drive(vq[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("v%0d_result", i), result, vq[i].res);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vq[i].err));
        end

        // Backpressure: the held response must not move.
        drive(mk(32'h0, 0, 3'b010, 0, 2'b01, 0, 0, 0));
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold", result, 32'h55667788);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("b2b_valid", 32'(rsp_valid), 32'h1);
        chk("b2b_result", result, 32'hCAFEF00D);

        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(rsp_valid), 32'h0);

        // Asynchronous reset while FULL, and no write while in reset.
        drive(mk(32'h0, 0, 3'b010, 0, 2'b01, 0, 0, 0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'h0);
        chk("async_rst_result", result, 32'h0);
        chk("async_rst_err", 32'(err), 32'h0);
        chk("async_rst_ready", 32'(req_ready), 32'h1);
        drive(mk(32'h0, 1, 3'b010, 32'hBAD0BAD0, 2'b00, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("in_rst_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        drive(mk(32'h0, 0, 3'b010, 0, 2'b01, 0, 0, 0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("post_rst_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_mem", result, 32'hCAFEF00D);
        chk("post_rst_err", 32'(err), 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
